// File: rtl/fpu_lane_arb.sv
// Two-lane round-robin arbiter for a shared FPU with per-op-class latency timing.
// Build option: JX2_FPUARB_FASTMUL_EN shortens MUL latency from 6 to 4 cycles.
//
// state | meaning
// IDLE  | no operation in flight; a valid lane may be granted this cycle
// EXEC  | FPU owned by fpuSel; counter runs down to the done cycle
module fpu_lane_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] reqValid,
  input  logic [2:0] reqOpA,
  input  logic [2:0] reqOpB,
  input  logic       flush,
  output logic       fpuStart,
  output logic       fpuSel,
  output logic [2:0] fpuOp,
  output logic [1:0] doneValid,
  output logic [1:0] busyHold
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, stateNext;
  logic [2:0] count, countNext;
  logic       ptr, ptrNext;
  logic       startNext;
  logic       selNext;
  logic [2:0] opNext;
  logic [1:0] arbReq;
  logic       grantLane;
  logic       done;

  function automatic logic [2:0] opLatency(input logic [2:0] opClass);
    case (opClass)
      3'd0, 3'd1: opLatency = 3'd6;
`ifdef JX2_FPUARB_FASTMUL_EN
      3'd2:       opLatency = 3'd4;
`else
      3'd2:       opLatency = 3'd6;
`endif
      3'd3:       opLatency = 3'd2;
      3'd4:       opLatency = 3'd4;
      default:    opLatency = 3'd1;
    endcase
  endfunction

  always_comb begin
    stateNext = state;
    countNext = count;
    ptrNext   = ptr;
    selNext   = fpuSel;
    opNext    = fpuOp;
    startNext = 1'b0;
    done      = 1'b0;
    arbReq    = 2'b00;
    grantLane = 1'b0;

    case (state)
      IDLE: begin
        if (!flush) arbReq = reqValid;
      end
      EXEC: begin
        if (flush) begin
          stateNext = IDLE;
        end else if (count == 3'd0) begin
          // Completion cycle: the finishing lane is masked so the other can issue back-to-back.
          done      = 1'b1;
          arbReq    = reqValid & ~{fpuSel, ~fpuSel};
          stateNext = IDLE;
        end else begin
          countNext = count - 3'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (arbReq != 2'b00) begin
      grantLane = (arbReq == 2'b11) ? ptr : arbReq[1];
      stateNext = EXEC;
      selNext   = grantLane;
      opNext    = grantLane ? reqOpB : reqOpA;
      countNext = opLatency(opNext) - 3'd1;
      ptrNext   = ~grantLane;
      startNext = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 3'd0;
      ptr      <= 1'b0;
      fpuStart <= 1'b0;
      fpuSel   <= 1'b0;
      fpuOp    <= 3'd0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      ptr      <= ptrNext;
      fpuStart <= startNext;
      fpuSel   <= selNext;
      fpuOp    <= opNext;
    end
  end

  assign doneValid = {done & fpuSel, done & ~fpuSel};
  assign busyHold  = reqValid & ~doneValid;

endmodule
